// File: rtl/cfu_dot_issuer.sv
// cfu_dot_issuer
//   Command-side initiator for the CFU dot-product responder. Takes one job
//   (block count, input offset, bias), streams 16-byte input/filter blocks
//   from a word feed and issues the op sequence
//     CLEAR, OFFSET, {LD0, LD1, LD2, LD3, ACC} x num_blocks, BIAS, READ
//   over the cmd/rsp handshake, one command outstanding at a time. The READ
//   response is returned on the result handshake.
//
// Ports
//   clk, reset (async, active-low)
//   job_*      : job request (valid/ready), num_blocks, signed offset, signed bias
//   data_*     : word-pair feed, one input word and one filter word per transfer
//   cmd_*      : command to CFU, function_id = {op[6:0], 3'b000}
//   rsp_*      : CFU response
//   res_*      : final accumulator (valid/ready)
//   busy       : high whenever a job is in progress
module cfu_dot_issuer #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [CNT_W-1:0]   job_num_blocks,
  input  logic signed [7:0]  job_input_offset,
  input  logic signed [31:0] job_bias,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic [31:0]        data_in_word,
  input  logic [31:0]        data_filter_word,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [9:0]         cmd_payload_function_id,
  output logic [31:0]        cmd_payload_inputs_0,
  output logic [31:0]        cmd_payload_inputs_1,
  input  logic               rsp_valid,
  output logic               rsp_ready,
  input  logic [31:0]        rsp_payload_outputs_0,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_data,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_RSP,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    ST_CLEAR,
    ST_OFFSET,
    ST_LD0,
    ST_LD1,
    ST_LD2,
    ST_LD3,
    ST_ACC,
    ST_BIAS,
    ST_READ
  } step_t;

  function automatic logic [9:0] step_fid(input step_t s);
    logic [6:0] op;
    case (s)
      ST_CLEAR:  op = 7'd1;
      ST_OFFSET: op = 7'd6;
      ST_LD0:    op = 7'd2;
      ST_LD1:    op = 7'd3;
      ST_LD2:    op = 7'd4;
      ST_LD3:    op = 7'd5;
      ST_ACC:    op = 7'd7;
      ST_BIAS:   op = 7'd9;
      ST_READ:   op = 7'd8;
      default:   op = 7'd0;
    endcase
    return {op, 3'b000};
  endfunction

  function automatic logic is_load(input step_t s);
    return (s == ST_LD0) || (s == ST_LD1) || (s == ST_LD2) || (s == ST_LD3);
  endfunction

  function automatic logic [31:0] step_arg0(input step_t s,
                                            input logic signed [7:0] off,
                                            input logic signed [31:0] bias);
    case (s)
      ST_OFFSET: return {{24{off[7]}}, off};
      ST_BIAS:   return bias;
      default:   return 32'd0;
    endcase
  endfunction

  state_t                state_q, state_n;
  step_t                 step_q, step_n;
  step_t                 adv_step;
  logic                  adv_valid;
  logic [CNT_W-1:0]      blk_cnt_q, blk_cnt_n;
  logic [CNT_W-1:0]      num_blocks_q, num_blocks_n;
  logic [CNT_W:0]        blk_inc;
  logic signed [7:0]     offset_q, offset_n;
  logic signed [31:0]    bias_q, bias_n;
  logic [9:0]            fid_q, fid_n;
  logic [31:0]           in0_q, in0_n;
  logic [31:0]           in1_q, in1_n;
  logic [31:0]           res_q, res_n;

  // One extra bit so num_blocks = 2^CNT_W-1 compares without wrapping.
  assign blk_inc = {1'b0, blk_cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    state_n      = state_q;
    step_n       = step_q;
    blk_cnt_n    = blk_cnt_q;
    num_blocks_n = num_blocks_q;
    offset_n     = offset_q;
    bias_n       = bias_q;
    fid_n        = fid_q;
    in0_n        = in0_q;
    in1_n        = in1_q;
    res_n        = res_q;
    adv_step     = step_q;
    adv_valid    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          num_blocks_n = job_num_blocks;
          offset_n     = job_input_offset;
          bias_n       = job_bias;
          blk_cnt_n    = '0;
          step_n       = ST_CLEAR;
          fid_n        = step_fid(ST_CLEAR);
          in0_n        = 32'd0;
          in1_n        = 32'd0;
          state_n      = S_ISSUE;
        end
      end
      S_FETCH: begin
        if (data_valid) begin
          fid_n   = step_fid(step_q);
          in0_n   = data_in_word;
          in1_n   = data_filter_word;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) state_n = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (rsp_valid) begin
          adv_valid = 1'b1;
          case (step_q)
            ST_CLEAR:  adv_step = ST_OFFSET;
            ST_OFFSET: adv_step = (num_blocks_q == '0) ? ST_BIAS : ST_LD0;
            ST_LD0:    adv_step = ST_LD1;
            ST_LD1:    adv_step = ST_LD2;
            ST_LD2:    adv_step = ST_LD3;
            ST_LD3:    adv_step = ST_ACC;
            ST_ACC: begin
              blk_cnt_n = blk_inc[CNT_W-1:0];
              adv_step  = (blk_inc == {1'b0, num_blocks_q}) ? ST_BIAS : ST_LD0;
            end
            ST_BIAS:   adv_step = ST_READ;
            ST_READ: begin
              adv_step = ST_READ;
              res_n    = rsp_payload_outputs_0;
            end
            default:   adv_step = ST_CLEAR;
          endcase
        end
      end
      S_DONE: begin
        if (res_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (adv_valid) begin
      step_n = adv_step;
      if (step_q == ST_READ) begin
        state_n = S_DONE;
      end else if (is_load(adv_step)) begin
        state_n = S_FETCH;
      end else begin
        fid_n   = step_fid(adv_step);
        in0_n   = step_arg0(adv_step, offset_q, bias_q);
        in1_n   = 32'd0;
        state_n = S_ISSUE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      step_q       <= ST_CLEAR;
      blk_cnt_q    <= '0;
      num_blocks_q <= '0;
      offset_q     <= '0;
      bias_q       <= '0;
      fid_q        <= '0;
      in0_q        <= '0;
      in1_q        <= '0;
      res_q        <= '0;
    end else begin
      state_q      <= state_n;
      step_q       <= step_n;
      blk_cnt_q    <= blk_cnt_n;
      num_blocks_q <= num_blocks_n;
      offset_q     <= offset_n;
      bias_q       <= bias_n;
      fid_q        <= fid_n;
      in0_q        <= in0_n;
      in1_q        <= in1_n;
      res_q        <= res_n;
    end
  end

  // Handshake outputs decode the state register only, so nothing from
  // cmd_ready/rsp_valid reaches cmd_valid combinationally.
  assign job_ready               = (state_q == S_IDLE);
  assign busy                    = (state_q != S_IDLE);
  assign data_ready              = (state_q == S_FETCH);
  assign cmd_valid               = (state_q == S_ISSUE);
  assign rsp_ready               = (state_q == S_WAIT_RSP);
  assign res_valid               = (state_q == S_DONE);
  assign cmd_payload_function_id = fid_q;
  assign cmd_payload_inputs_0    = in0_q;
  assign cmd_payload_inputs_1    = in1_q;
  assign res_data                = res_q;

endmodule

// File: tb/tb_cfu_dot_issuer.sv
// Testbench for cfu_dot_issuer: a behavioural CFU responder, a word feed and
// a result sink drive the DUT; a negedge monitor checks every command and
// result against scoreboard queues filled by the stimulus.
module tb_cfu_dot_issuer;

  localparam int CNT_W = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               job_valid = 1'b0;
  logic               job_ready;
  logic [CNT_W-1:0]   job_num_blocks = '0;
  logic [7:0]         job_input_offset = '0;
  logic [31:0]        job_bias = '0;
  logic               data_valid = 1'b0;
  logic               data_ready;
  logic [31:0]        data_in_word = '0;
  logic [31:0]        data_filter_word = '0;
  logic               cmd_valid;
  logic               cmd_ready = 1'b0;
  logic [9:0]         cmd_payload_function_id;
  logic [31:0]        cmd_payload_inputs_0;
  logic [31:0]        cmd_payload_inputs_1;
  logic               rsp_valid = 1'b0;
  logic               rsp_ready;
  logic [31:0]        rsp_payload_outputs_0 = '0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [31:0]        res_data;
  logic               busy;

  always #5 clk = ~clk;

  cfu_dot_issuer #(.CNT_W(CNT_W)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .job_valid               (job_valid),
    .job_ready               (job_ready),
    .job_num_blocks          (job_num_blocks),
    .job_input_offset        (job_input_offset),
    .job_bias                (job_bias),
    .data_valid              (data_valid),
    .data_ready              (data_ready),
    .data_in_word            (data_in_word),
    .data_filter_word        (data_filter_word),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .res_valid               (res_valid),
    .res_ready               (res_ready),
    .res_data                (res_data),
    .busy                    (busy)
  );

  typedef struct {
    logic [9:0]  fid;
    logic [31:0] in0;
    logic [31:0] in1;
  } cmd_t;

  cmd_t        exp_cmd[$];
  logic [31:0] exp_res[$];
  logic [63:0] feed_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  int cfg_cmd_stall = 0;
  int cfg_rsp_delay = 0;
  int cfg_data_gap  = 0;
  int cfg_res_delay = 0;

  // monitor statistics
  int cmd_hs_cnt = 0, data_hs_cnt = 0, res_hs_cnt = 0;
  int dready_cycles = 0, stall_viol = 0, overlap_viol = 0;
  logic cmd_hs_s = 1'b0, rsp_hs_s = 1'b0, data_hs_s = 1'b0, res_hs_s = 1'b0;

  // CFU model state
  logic model_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        prev_cmd_stall = 1'b0;
    logic [9:0]  prev_fid = '0;
    logic [31:0] prev_in0 = '0, prev_in1 = '0;
    logic        prev_res_stall = 1'b0;
    logic [31:0] prev_res = '0;
    cmd_t        e;
    logic [31:0] er;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cmd_hs_s = 1'b0; rsp_hs_s = 1'b0; data_hs_s = 1'b0; res_hs_s = 1'b0;
        prev_cmd_stall = 1'b0; prev_res_stall = 1'b0;
      end else begin
        cmd_hs_s  = cmd_valid && cmd_ready;
        rsp_hs_s  = rsp_valid && rsp_ready;
        data_hs_s = data_valid && data_ready;
        res_hs_s  = res_valid && res_ready;
        if (data_ready) dready_cycles++;
        if (prev_cmd_stall && cmd_valid &&
            (cmd_payload_function_id !== prev_fid || cmd_payload_inputs_0 !== prev_in0 ||
             cmd_payload_inputs_1 !== prev_in1))
          stall_viol++;
        if (prev_cmd_stall && !cmd_valid) stall_viol++;
        prev_cmd_stall = cmd_valid && !cmd_ready;
        prev_fid = cmd_payload_function_id;
        prev_in0 = cmd_payload_inputs_0;
        prev_in1 = cmd_payload_inputs_1;
        if (prev_res_stall && (res_data !== prev_res || !res_valid)) stall_viol++;
        prev_res_stall = res_valid && !res_ready;
        prev_res = res_data;
        if (cmd_valid && model_pending) overlap_viol++;
        if (data_hs_s) data_hs_cnt++;
        if (cmd_hs_s) begin
          cmd_hs_cnt++;
          if (exp_cmd.size() == 0) begin
            n_checks++;
            $display("FAIL cmd_unexpected: got fid 0x%03h with no command expected",
                     cmd_payload_function_id);
          end else begin
            e = exp_cmd.pop_front();
            check("cmd_fid", {22'd0, cmd_payload_function_id}, {22'd0, e.fid});
            check("cmd_in0", cmd_payload_inputs_0, e.in0);
            check("cmd_in1", cmd_payload_inputs_1, e.in1);
          end
        end
        if (res_hs_s) begin
          res_hs_cnt++;
          if (exp_res.size() == 0) begin
            n_checks++;
            $display("FAIL res_unexpected: got 0x%08h with no result expected", res_data);
          end else begin
            er = exp_res.pop_front();
            check("res_data", res_data, er);
          end
        end
      end
    end
  end

  // ---------------- CFU responder model ----------------
  initial begin
    int          acc = 0, off_r = 0, rsp_wait = 0, stall_cnt = 0;
    logic [31:0] rv = '0;
    logic [31:0] inw[4];
    logic [31:0] fw[4];
    logic [6:0]  op;
    logic signed [7:0] ib, fb;
    for (int i = 0; i < 4; i++) begin inw[i] = '0; fw[i] = '0; end
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        model_pending = 1'b0; rsp_valid = 1'b0; cmd_ready = 1'b0; stall_cnt = 0;
      end else begin
        if (cmd_hs_s) begin
          op = cmd_payload_function_id[9:3];
          rv = 32'hA5A5_0000 | {25'd0, op};
          case (op)
            7'd1: acc = 0;
            7'd6: off_r = int'($signed(cmd_payload_inputs_0));
            7'd2, 7'd3, 7'd4, 7'd5: begin
              inw[op - 7'd2] = cmd_payload_inputs_0;
              fw[op - 7'd2]  = cmd_payload_inputs_1;
            end
            7'd7: begin
              for (int w = 0; w < 4; w++)
                for (int b = 0; b < 4; b++) begin
                  ib = inw[w][8*b +: 8];
                  fb = fw[w][8*b +: 8];
                  acc += (int'(ib) + off_r + 128) * int'(fb);
                end
            end
            7'd9: acc += int'($signed(cmd_payload_inputs_0));
            7'd8: rv = acc;
            default: ;
          endcase
          model_pending = 1'b1;
          rsp_wait = cfg_rsp_delay;
          cmd_ready = 1'b0;
        end
        if (rsp_hs_s) begin
          rsp_valid = 1'b0;
          model_pending = 1'b0;
        end
        if (model_pending && !rsp_valid) begin
          if (rsp_wait == 0) begin
            rsp_valid = 1'b1;
            rsp_payload_outputs_0 = rv;
          end else rsp_wait--;
        end
        if (!model_pending && cmd_valid) begin
          if (stall_cnt < cfg_cmd_stall) begin
            stall_cnt++;
            cmd_ready = 1'b0;
          end else cmd_ready = 1'b1;
        end else begin
          cmd_ready = 1'b0;
          stall_cnt = 0;
        end
      end
    end
  end

  // ---------------- word feed ----------------
  initial begin
    int   gap = 0;
    logic [63:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        data_valid = 1'b0; gap = 0;
      end else begin
        if (data_hs_s) begin
          w = feed_q.pop_front();
          data_valid = 1'b0;
          gap = cfg_data_gap;
        end
        if (!data_valid) begin
          if (gap > 0) gap--;
          else if (feed_q.size() > 0) begin
            data_valid = 1'b1;
            {data_in_word, data_filter_word} = feed_q[0];
          end
        end
      end
    end
  end

  // ---------------- result sink ----------------
  initial begin
    int rc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset || res_hs_s) begin
        res_ready = 1'b0; rc = 0;
      end else if (res_valid) begin
        if (rc >= cfg_res_delay) res_ready = 1'b1;
        else rc++;
      end
    end
  end

  // ---------------- stimulus ----------------
  int c0, d0, r0, dr0, s0, o0;

  task automatic push_cmd(input int op, input logic [31:0] a0, input logic [31:0] a1);
    cmd_t c;
    c.fid = {7'(op), 3'b000};
    c.in0 = a0;
    c.in1 = a1;
    exp_cmd.push_back(c);
  endtask

  task automatic start_job(input int nb, input logic [7:0] off, input logic [31:0] bias,
                           input logic [31:0] iw, input logic [31:0] fw,
                           input logic [31:0] exp_result);
    c0 = cmd_hs_cnt; d0 = data_hs_cnt; r0 = res_hs_cnt;
    dr0 = dready_cycles; s0 = stall_viol; o0 = overlap_viol;
    push_cmd(1, 32'd0, 32'd0);
    push_cmd(6, {{24{off[7]}}, off}, 32'd0);
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 4; k++) begin
        push_cmd(2 + k, iw, fw);
        feed_q.push_back({iw, fw});
      end
      push_cmd(7, 32'd0, 32'd0);
    end
    push_cmd(9, bias, 32'd0);
    push_cmd(8, 32'd0, 32'd0);
    exp_res.push_back(exp_result);
    @(posedge clk);
    #1;
    job_valid = 1'b1;
    job_num_blocks = 16'(nb);
    job_input_offset = off;
    job_bias = bias;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (job_ready) break;
    end
    @(posedge clk);
    #1;
    job_valid = 1'b0;
  endtask

  task automatic finish_job(input string tag, input int nb);
    logic done = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      if (res_hs_cnt != r0) begin done = 1'b1; break; end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s_timeout: no result after 5000 cycles, required one", tag);
    end
    @(negedge clk);
    check({tag, "_cmd_count"}, cmd_hs_cnt - c0, 4 + 5 * nb);
    check({tag, "_data_hs"}, data_hs_cnt - d0, 4 * nb);
    check({tag, "_stall_stable"}, stall_viol - s0, 0);
    check({tag, "_one_outstanding"}, overlap_viol - o0, 0);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd1 - {31'd0, job_ready});
    check({tag, "_job_ready_after"}, {31'd0, job_ready}, 1);
    check({tag, "_cmd_q_empty"}, exp_cmd.size(), 0);
    if (nb == 0) check({tag, "_dready_cycles"}, dready_cycles - dr0, 0);
  endtask

  initial begin
    logic done;
    // reset state while held in reset
    @(posedge clk);
    #2;
    check("rst_cmd_valid", {31'd0, cmd_valid}, 0);
    check("rst_rsp_ready", {31'd0, rsp_ready}, 0);
    check("rst_res_valid", {31'd0, res_valid}, 0);
    check("rst_data_ready", {31'd0, data_ready}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_job_ready", {31'd0, job_ready}, 1);
    check("rst_fid", {22'd0, cmd_payload_function_id}, 0);
    check("rst_res_data", res_data, 0);
    @(negedge clk);
    reset = 1'b1;

    start_job(1, 8'd0, 32'd0, 32'h0000_0000, 32'h0101_0101, 32'd2048);
    finish_job("j1", 1);

    start_job(1, 8'd0, 32'd100, 32'h0000_0000, 32'h0101_0101, 32'd2148);
    finish_job("j_bias", 1);

    start_job(2, 8'd0, 32'd0, 32'h0000_0000, 32'h0101_0101, 32'd4096);
    finish_job("j_two", 2);

    start_job(0, 8'd0, 32'hFFFF_FFFB, 32'h0, 32'h0, 32'hFFFF_FFFB);
    finish_job("j_zero", 0);

    cfg_cmd_stall = 5; cfg_rsp_delay = 3; cfg_data_gap = 2; cfg_res_delay = 4;
    start_job(1, 8'd0, 32'd0, 32'h0000_0000, 32'h0101_0101, 32'd2048);
    finish_job("j_stall", 1);
    cfg_cmd_stall = 0; cfg_rsp_delay = 0; cfg_data_gap = 0; cfg_res_delay = 0;

    start_job(1, 8'h80, 32'd7, 32'h0000_0000, 32'h0101_0101, 32'd7);
    finish_job("j_negoff", 1);

    start_job(1, 8'd0, 32'd0, 32'h0403_0201, 32'h0101_0101, 32'd2088);
    finish_job("j_bytes", 1);

    // reset during WAIT_RSP of LD2
    cfg_rsp_delay = 6;
    start_job(1, 8'd0, 32'd0, 32'h0000_0000, 32'h0101_0101, 32'd2048);
    done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cmd_hs_cnt - c0 == 5 && rsp_ready) begin done = 1'b1; break; end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL rst_mid_timeout: LD2 response wait not reached, required it");
    end
    check("mid_fid_before", {22'd0, cmd_payload_function_id}, {22'd0, 7'd4, 3'b000});
    #2;
    reset = 1'b0;
    #1;
    check("mid_cmd_valid", {31'd0, cmd_valid}, 0);
    check("mid_rsp_ready", {31'd0, rsp_ready}, 0);
    check("mid_data_ready", {31'd0, data_ready}, 0);
    check("mid_res_valid", {31'd0, res_valid}, 0);
    check("mid_busy", {31'd0, busy}, 0);
    check("mid_job_ready", {31'd0, job_ready}, 1);
    check("mid_fid", {22'd0, cmd_payload_function_id}, 0);
    check("mid_in0", cmd_payload_inputs_0, 0);
    check("mid_in1", cmd_payload_inputs_1, 0);
    check("mid_res_data", res_data, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    exp_cmd.delete();
    exp_res.delete();
    feed_q.delete();
    cfg_rsp_delay = 0;
    @(negedge clk);
    reset = 1'b1;
    start_job(1, 8'd0, 32'd0, 32'h0000_0000, 32'h0101_0101, 32'd2048);
    finish_job("j_after_rst", 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
